// File: rtl/lfsr_seed_gen.sv
// Seed-pattern generator: a 16-bit Fibonacci LFSR fills a WIDTH-bit pattern one bit per enabled cycle.
// Optional: define LFSR_AUTO_RELOAD_EN to restart a fill from DONE on en instead of waiting for lfsr_rst.
module lfsr_seed_gen #(
  parameter int unsigned WIDTH = 64,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lfsr_rst,
  input  logic             en,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] pattern,
  output logic             busy
);

  localparam int unsigned CW       = $clog2(WIDTH + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [CW-1:0]   cnt;
  logic [15:0]     lfsr_next;
  logic [WIDTH-1:0] pattern_upd;

  // x^16+x^14+x^13+x^11+1, shifting toward bit 0; bit 0 is the output bit
  assign lfsr_next   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign pattern_upd = (pattern & ~(WIDTH'(1) << cnt)) | (WIDTH'(lfsr[0]) << cnt);
  assign busy        = (state == FILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      cnt       <= '0;
      pattern   <= '0;
      lfsr_load <= 1'b0;
    end else if (lfsr_rst) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      cnt       <= '0;
      lfsr_load <= 1'b0;
    end else begin
      lfsr_load <= 1'b0;
      case (state)
        IDLE: begin
          // the IDLE->FILL edge already captures bit 0
          if (en) begin
            state   <= FILL;
            pattern <= pattern_upd;
            lfsr    <= lfsr_next;
            cnt     <= CW'(1);
          end
        end
        FILL: begin
          if (en) begin
            pattern <= pattern_upd;
            lfsr    <= lfsr_next;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state     <= DONE;
              lfsr_load <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef LFSR_AUTO_RELOAD_EN
          // re-enter FILL without stepping; the sequence continues unreseeded
          if (en) begin
            state <= FILL;
            cnt   <= '0;
          end
`else
          state <= DONE;
`endif
        end
        default: begin
          state     <= IDLE;
          lfsr      <= SEED_EFF;
          cnt       <= '0;
          pattern   <= '0;
          lfsr_load <= 1'b0;
        end
      endcase
    end
  end

endmodule
